pic_bus_control_logic: RTL and testbench

CPU-side read/write bus interface of the 8259A-compatible interrupt controller. Samples the chip-select, read, write and A0 strobes and the 8-bit data bus on the system clock. Latches write data onto the internal data bus. Decodes each completed write into one-cycle command-word strobes (ICW1, ICW2-4, OCW1, OCW2, OCW3) and produces a read-access flag for the data-out mux. Sits between the external CPU bus pins and the PIC control logic / register blocks.

---
 rtl/pic_bus_control_logic.sv | 100 ++++++++++
 tb/tb_pic_bus_control_logic.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pic_bus_control_logic.sv
// CPU-side bus interface of an 8259A-compatible PIC. It samples the strobes and write data,
// then decodes each completed write into one-cycle command-word strobes.
module pic_bus_control_logic #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  chip_select_n,
  input  logic                  read_enable_n,
  input  logic                  write_enable_n,
  input  logic                  A0,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic [DATA_WIDTH-1:0] internal_data_bus,
  output logic                  write_initial_command_word_1,
  output logic                  write_initial_command_word_2_4,
  output logic                  write_operation_control_word_1,
  output logic                  write_operation_control_word_2,
  output logic                  write_operation_control_word_3,
  output logic                  read
);

  logic                  wr_active;
  logic                  rd_active;
  logic                  wr_end;
  logic                  wr_prev_q;
  logic                  a0_latch_q;
  logic                  a0_latch_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  icw1_q, icw24_q, ocw1_q, ocw2_q, ocw3_q, read_q;
  logic                  icw1_d, icw24_d, ocw1_d, ocw2_d, ocw3_d;

  assign wr_active = ~chip_select_n & ~write_enable_n;
  // A simultaneous RD#/WR# is treated as a write only.
  assign rd_active = ~chip_select_n & ~read_enable_n & write_enable_n;
  assign wr_end    = wr_prev_q & ~wr_active;

  always_comb begin
    data_d     = data_q;
    a0_latch_d = a0_latch_q;
    if (wr_active) begin
      data_d     = data_bus_in;
      a0_latch_d = A0;
    end
  end

  // Strobes decode the values captured during the write, never the live bus.
  always_comb begin
    icw1_d  = 1'b0;
    icw24_d = 1'b0;
    ocw1_d  = 1'b0;
    ocw2_d  = 1'b0;
    ocw3_d  = 1'b0;
    if (wr_end) begin
      if (a0_latch_q) begin
        icw24_d = 1'b1;
        ocw1_d  = 1'b1;
      end else if (data_q[4]) begin
        icw1_d = 1'b1;
      end else if (data_q[3]) begin
        ocw3_d = 1'b1;
      end else begin
        ocw2_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_q     <= '0;
      a0_latch_q <= 1'b0;
      wr_prev_q  <= 1'b0;
      icw1_q     <= 1'b0;
      icw24_q    <= 1'b0;
      ocw1_q     <= 1'b0;
      ocw2_q     <= 1'b0;
      ocw3_q     <= 1'b0;
      read_q     <= 1'b0;
    end else begin
      data_q     <= data_d;
      a0_latch_q <= a0_latch_d;
      wr_prev_q  <= wr_active;
      icw1_q     <= icw1_d;
      icw24_q    <= icw24_d;
      ocw1_q     <= ocw1_d;
      ocw2_q     <= ocw2_d;
      ocw3_q     <= ocw3_d;
      read_q     <= rd_active;
    end
  end

  assign internal_data_bus              = data_q;
  assign write_initial_command_word_1   = icw1_q;
  assign write_initial_command_word_2_4 = icw24_q;
  assign write_operation_control_word_1 = ocw1_q;
  assign write_operation_control_word_2 = ocw2_q;
  assign write_operation_control_word_3 = ocw3_q;
  assign read                           = read_q;

endmodule

// File: tb/tb_pic_bus_control_logic.sv
// Bench for pic_bus_control_logic: directed command-word writes, reads and corner cases,
// then random bus traffic, all checked against a transaction-level reference model.
module tb_pic_bus_control_logic;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       chip_select_n = 1'b1;
  logic       read_enable_n = 1'b1;
  logic       write_enable_n = 1'b1;
  logic       A0 = 1'b0;
  logic [7:0] data_bus_in = 8'h00;
  logic [7:0] internal_data_bus;
  logic       write_initial_command_word_1;
  logic       write_initial_command_word_2_4;
  logic       write_operation_control_word_1;
  logic       write_operation_control_word_2;
  logic       write_operation_control_word_3;
  logic       read;

  int checks = 0;
  int errors = 0;

  // Reference model: the write currently in progress and the values it last carried.
  bit         m_in_write = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_a0 = 1'b0;
  logic [4:0] m_strobes = 5'b0;  // {icw1, icw2_4, ocw1, ocw2, ocw3}
  bit         m_read = 1'b0;

  localparam logic [4:0] SIcw1 = 5'b10000;
  localparam logic [4:0] SA0   = 5'b01100;
  localparam logic [4:0] SOcw2 = 5'b00010;
  localparam logic [4:0] SOcw3 = 5'b00001;

  pic_bus_control_logic #(.DATA_WIDTH(8)) dut (
    .clock                          (clock),
    .reset_n                        (reset_n),
    .chip_select_n                  (chip_select_n),
    .read_enable_n                  (read_enable_n),
    .write_enable_n                 (write_enable_n),
    .A0                             (A0),
    .data_bus_in                    (data_bus_in),
    .internal_data_bus              (internal_data_bus),
    .write_initial_command_word_1   (write_initial_command_word_1),
    .write_initial_command_word_2_4 (write_initial_command_word_2_4),
    .write_operation_control_word_1 (write_operation_control_word_1),
    .write_operation_control_word_2 (write_operation_control_word_2),
    .write_operation_control_word_3 (write_operation_control_word_3),
    .read                           (read)
  );

  always #5 clock = ~clock;

  function automatic logic [4:0] command_class(input logic [7:0] d, input bit a);
    if (a) return SA0;
    if (d[4]) return SIcw1;
    return d[3] ? SOcw3 : SOcw2;
  endfunction

  function automatic logic [4:0] dut_strobes();
    return {write_initial_command_word_1, write_initial_command_word_2_4,
            write_operation_control_word_1, write_operation_control_word_2,
            write_operation_control_word_3};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, update the model from what the edge sampled, check after it.
  task automatic step(input bit rst_n, input bit cs_n, input bit rd_n, input bit wr_n,
                      input bit a0, input logic [7:0] d);
    bit writing;
    @(negedge clock);
    reset_n = rst_n; chip_select_n = cs_n; read_enable_n = rd_n;
    write_enable_n = wr_n; A0 = a0; data_bus_in = d;
    @(posedge clock);
    writing = !cs_n && !wr_n;
    if (!rst_n) begin
      m_in_write = 0; m_data = 8'h00; m_a0 = 0; m_strobes = 5'b0; m_read = 0;
    end else begin
      m_read    = !cs_n && !rd_n && wr_n;
      m_strobes = (m_in_write && !writing) ? command_class(m_data, m_a0) : 5'b0;
      if (writing) begin
        m_data = d;
        m_a0   = a0;
      end
      m_in_write = writing;
    end
    #1;
    check("data", internal_data_bus, m_data);
    check("strobes", {3'b0, dut_strobes()}, {3'b0, m_strobes});
    check("read", {7'b0, read}, {7'b0, m_read});
  endtask

  task automatic idle();
    step(1, 1, 1, 1, 0, 8'h00);
  endtask

  task automatic write_cmd(input bit a0, input logic [7:0] d, input logic [4:0] exp, input string tag);
    step(1, 0, 1, 0, a0, d);
    step(1, 0, 1, 0, a0, d);
    step(1, 0, 1, 1, a0, d);
    check(tag, {3'b0, dut_strobes()}, {3'b0, exp});
    step(1, 0, 1, 1, a0, d);
    check({tag, "_one_cycle"}, {3'b0, dut_strobes()}, 8'h00);
  endtask

  initial begin
    // Reset with random bus activity.
    step(0, 0, $urandom_range(0, 1), 0, $urandom_range(0, 1), 8'($urandom));
    step(0, 0, $urandom_range(0, 1), 0, $urandom_range(0, 1), 8'($urandom));
    check("reset_data", internal_data_bus, 8'h00);
    check("reset_strobes", {3'b0, dut_strobes()}, 8'h00);
    check("reset_read", {7'b0, read}, 8'h00);
    idle();

    write_cmd(0, 8'hD0, SIcw1, "icw1");
    check("icw1_data", internal_data_bus, 8'hD0);
    write_cmd(0, 8'h08, SOcw3, "ocw3");
    write_cmd(0, 8'h20, SOcw2, "ocw2");
    write_cmd(1, 8'hFB, SA0, "a0_pair");
    check("a0_data", internal_data_bus, 8'hFB);

    // Extended write with changing A0/data: nothing until release.
    step(1, 0, 1, 0, 0, 8'hD0);
    step(1, 0, 1, 0, 0, 8'hD0);
    step(1, 0, 1, 0, 1, 8'h08);
    check("long_write_quiet", {3'b0, dut_strobes()}, 8'h00);
    step(1, 0, 1, 0, 1, 8'h08);
    step(1, 0, 1, 1, 0, 8'h00);
    check("long_write_release", {3'b0, dut_strobes()}, {3'b0, SA0});
    check("long_write_data", internal_data_bus, 8'h08);
    idle();

    // Read: one-edge latency, clears one edge after RD# rises.
    step(1, 0, 0, 1, 0, 8'h00);
    check("read_set", {7'b0, read}, 8'h01);
    step(1, 0, 1, 1, 0, 8'h00);
    check("read_clear", {7'b0, read}, 8'h00);
    // RD# and WR# both low: write wins.
    step(1, 0, 0, 0, 0, 8'h10);
    check("rd_wr_both", {7'b0, read}, 8'h00);
    step(1, 0, 1, 1, 0, 8'h10);
    check("rd_wr_both_icw1", {3'b0, dut_strobes()}, {3'b0, SIcw1});
    // CS# high: writes ignored.
    for (int i = 0; i < 6; i++) step(1, 1, 1, i[0], 0, 8'h55);
    check("cs_high_quiet", {3'b0, dut_strobes()}, 8'h00);
    // CS# release ends a write.
    step(1, 0, 1, 0, 0, 8'h00);
    step(1, 1, 1, 0, 0, 8'h00);
    check("cs_release_ocw2", {3'b0, dut_strobes()}, {3'b0, SOcw2});
    // Reset mid-write, write released while reset is low.
    step(1, 0, 1, 0, 0, 8'h10);
    step(0, 0, 1, 0, 0, 8'h10);
    step(0, 0, 1, 1, 0, 8'h10);
    step(1, 0, 1, 1, 0, 8'h10);
    check("reset_mid_write", {3'b0, dut_strobes()}, 8'h00);
    // Reset on the end-of-write edge.
    step(1, 0, 1, 0, 1, 8'h33);
    step(0, 0, 1, 1, 1, 8'h33);
    check("reset_on_release", {3'b0, dut_strobes()}, 8'h00);
    idle();

    // Random traffic: writes of varied length, reads, CS# gaps and rare resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 40) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1),
           $urandom_range(0, 2) == 0 ? ~write_enable_n : write_enable_n,
           $urandom_range(0, 1), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
